cpu6502_bus_seq: RTL and testbench
==================================

Name: cpu6502_bus_seq

Overview:
- Parametrised bus sequencer for the 6502 cores in the arcade tree; it replaces the fixed phi0/phi2 inversion with a proper sequencer.
- Divides the system clock into CPU cycles and generates phi0/phi2 plus one-clock phase-edge clock enables.
- Stretches the phi2-high phase by a wait-state count for slow regions, and arbitrates RDY for DMA/halt requests, respecting the 6502 rule that writes cannot be stalled.
- Synchronises IRQ/NMI and presents them only at cycle boundaries.

Parameters:
DIV, 12, system clocks per unstretched CPU cycle; minimum 2; phi2-low phase = DIV/2 clocks (integer), phi2-high phase = DIV-DIV/2 clocks
SLOW_WAIT, 0, extra clocks added to the phi2-high phase when slow is sampled high; minimum 0
SYNC_STAGES, 2, flip-flop stages on irq_n_in/nmi_n_in; minimum 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = sequencer runs; 0 = freeze
slow  in  1  current address is in a slow region (from address decoder)
rw_n  in  1  CPU read/write strobe for the current cycle (1 = read)
halt_req  in  1  DMA/halt request
irq_n_in  in  1  raw asynchronous IRQ, active low
nmi_n_in  in  1  raw asynchronous NMI, active low
phi0  out  1  CPU clock input, always ~phi2
phi2  out  1  bus phase; high = data phase
ce_rise  out  1  one-clock pulse; phi2 rises on the next clk
ce_fall  out  1  one-clock pulse; phi2 falls and the CPU cycle ends on the next clk
rdy  out  1  to CPU RDY
halt_ack  out  1  CPU is stalled on a read cycle; bus is free
irq_n  out  1  synchronised IRQ to CPU
nmi_n  out  1  synchronised NMI to CPU

Behaviour:
- Reset (asynchronous, any time, including mid-cycle or mid-stretch):
  - counter 0, stretch flag 0, phi2 0, phi0 1, ce_rise 0, ce_fall 0.
  - rdy 1, halt_ack 0, irq_n 1, nmi_n 1, all sync stages 1.
  - The first cycle after reset release is a full-length cycle.
- Counter width: $clog2(DIV+SLOW_WAIT+1).
- Each enabled clk the counter counts from 0 to L-1, then wraps to 0.
  - L = DIV, or DIV+SLOW_WAIT when the stretch flag is set.
- phi2 is registered: 0 while counter < DIV/2, else 1. phi0 is the registered complement; the two never overlap or gap.
- ce_rise is high in the clk where counter == DIV/2-1. ce_fall is high in the clk where counter == L-1.
- Stretch flag:
  - Loaded from slow when ce_rise fires.
  - Cleared at the wrap.
  - slow changing during phi2-high has no effect.
  - With SLOW_WAIT = 0 the flag has no effect.
- enable = 0: counter, phi levels, rdy, halt_ack, irq_n and nmi_n hold; ce_rise and ce_fall are forced to 0. Sync stages keep shifting. Resuming continues the same cycle exactly.
- RDY/halt:
  - rdy is loaded with ~halt_req at each ce_fall, so it changes only at cycle boundaries.
  - At ce_fall: halt_ack = ~rdy_current & rw_n & halt_req.
    - A cycle with rdy = 0 and rw_n = 0 is a write the CPU will not stall, so no ack is given.
    - Dropping halt_req clears halt_ack and sets rdy at the same ce_fall.
- Interrupts:
  - SYNC_STAGES-deep synchronisers on each raw input.
  - irq_n and nmi_n are updated from the last sync stage only at ce_fall.
  - Level passthrough; NMI edge detection stays inside the CPU core.
- Simultaneous events:
  - ce_rise and ce_fall never coincide, since DIV ≥ 2.
  - halt_req and slow in the same cycle: both take effect independently.

Test Plan:
- DIV=4, SLOW_WAIT=2, slow=0, enable=1 after reset release → phi2 = 0,0,1,1 repeating; ce_rise at counter 1; ce_fall at counter 3; phi0 = ~phi2 every clk.
- slow=1 held → phi2 high for 4 clks, period 6; slow=1 only before ce_rise, dropped right after → still period 6; slow=1 only after ce_rise → period 4.
- halt_req=1 during a write cycle (rw_n=0) → rdy 0 at next ce_fall; halt_ack stays 0 at the ce_fall ending the write; first read cycle (rw_n=1) → halt_ack 1 at its ce_fall. Drop halt_req → rdy 1, halt_ack 0 at the same ce_fall.
- nmi_n_in 1→0 mid-cycle, SYNC_STAGES=2 → nmi_n falls exactly at the first ce_fall occurring ≥2 clks later, never between boundaries; same check for irq_n.
- enable=0 for 5 clks at counter 2 → no ce pulses and phi2 held 1; enable=1 → ce_fall one clk later, period resumes.
- Assert reset during a stretched phi2-high phase → immediately phi2 0, phi0 1, rdy 1, halt_ack 0; after release, first cycle is 4 clks with no stretch.

Source files
------------

// File: rtl/cpu6502_bus_seq_if.sv
// Bus between the 6502 bus sequencer and the CPU core / system glue.
// Handshake: the sequencer owns the phase outputs; ce_rise/ce_fall are
// one-clock qualifiers valid only in the clk they are high. rdy and
// halt_ack change only at cycle boundaries. halt_ack set means the CPU is
// parked on a read and the bus may be used by the requester.
`timescale 1ns/1ps
interface cpu6502_bus_seq_if;
    logic enable;
    logic slow;
    logic rw_n;
    logic halt_req;
    logic irq_n_in;
    logic nmi_n_in;
    logic phi0;
    logic phi2;
    logic ce_rise;
    logic ce_fall;
    logic rdy;
    logic halt_ack;
    logic irq_n;
    logic nmi_n;

    // Sequencer side
    modport master (
        input  enable, slow, rw_n, halt_req, irq_n_in, nmi_n_in,
        output phi0, phi2, ce_rise, ce_fall, rdy, halt_ack, irq_n, nmi_n
    );

    // CPU / glue side
    modport slave (
        output enable, slow, rw_n, halt_req, irq_n_in, nmi_n_in,
        input  phi0, phi2, ce_rise, ce_fall, rdy, halt_ack, irq_n, nmi_n
    );
endinterface

// File: rtl/cpu6502_bus_seq.sv
// 6502 bus sequencer: divides clk into CPU cycles, generates phi0/phi2 and
// phase-edge clock enables, stretches phi2-high for slow regions, arbitrates
// RDY for halt/DMA (never stalling writes) and presents synchronised
// IRQ/NMI only at cycle boundaries.
`timescale 1ns/1ps
module cpu6502_bus_seq #(
    parameter int DIV         = 12,
    parameter int SLOW_WAIT   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    cpu6502_bus_seq_if.master   bus
);
    localparam int CW = $clog2(DIV + SLOW_WAIT + 1);
    localparam int HALF = DIV / 2;
    localparam logic [CW-1:0] HALF_C  = CW'(HALF);
    localparam logic [CW-1:0] RISE_AT = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST_N  = CW'(DIV - 1);
    localparam logic [CW-1:0] LAST_S  = CW'(DIV + SLOW_WAIT - 1);

    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic [CW-1:0]          last;
    logic                   stretch;
    logic                   at_rise;
    logic                   at_fall;
    logic                   phi2_next;
    logic                   phi2_q;
    logic                   phi0_q;
    logic                   rdy_q;
    logic                   ack_q;
    logic                   irq_q;
    logic                   nmi_q;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] nmi_sync;

    // Cycle length depends on whether this cycle's phi2-high was stretched.
    assign last       = stretch ? LAST_S : LAST_N;
    assign at_rise    = (count == RISE_AT);
    assign at_fall    = (count == last);
    assign count_next = at_fall ? '0 : count + 1'b1;
    assign phi2_next  = (count_next >= HALF_C);

    // Enables are gated by enable so a frozen sequencer emits no edges.
    assign bus.ce_rise  = bus.enable & at_rise;
    assign bus.ce_fall  = bus.enable & at_fall;
    assign bus.phi2     = phi2_q;
    assign bus.phi0     = phi0_q;
    assign bus.rdy      = rdy_q;
    assign bus.halt_ack = ack_q;
    assign bus.irq_n    = irq_q;
    assign bus.nmi_n    = nmi_q;

    // Interrupt synchronisers shift every clk, independent of enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_sync <= '1;
            nmi_sync <= '1;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], bus.irq_n_in};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], bus.nmi_n_in};
        end
    end

    // Cycle counter, phase registers, stretch flag and boundary-updated outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            stretch <= 1'b0;
            phi2_q  <= 1'b0;
            phi0_q  <= 1'b1;
            rdy_q   <= 1'b1;
            ack_q   <= 1'b0;
            irq_q   <= 1'b1;
            nmi_q   <= 1'b1;
        end else if (bus.enable) begin
            count  <= count_next;
            phi2_q <= phi2_next;
            phi0_q <= ~phi2_next;
            if (at_fall) begin
                stretch <= 1'b0;
                rdy_q   <= ~bus.halt_req;
                // A write with rdy low still completes, so it earns no ack.
                ack_q   <= ~rdy_q & bus.rw_n & bus.halt_req;
                irq_q   <= irq_sync[SYNC_STAGES-1];
                nmi_q   <= nmi_sync[SYNC_STAGES-1];
            end else if (at_rise) begin
                stretch <= bus.slow;
            end
        end
    end
endmodule

// File: tb/tb_cpu6502_bus_seq.sv
// Bench for cpu6502_bus_seq with DIV=4, SLOW_WAIT=2, SYNC_STAGES=2.
// Driver pushes the expected output vector for each clk; a negedge monitor
// pops and compares. Vector bit order:
// {phi2, phi0, ce_rise, ce_fall, rdy, halt_ack, irq_n, nmi_n}
// Input vector bit order: {enable, slow, rw_n, halt_req, irq_n_in, nmi_n_in}
`timescale 1ns/1ps
module tb_cpu6502_bus_seq;
    localparam logic [5:0] IN_STOP = 6'b001011;
    localparam logic [5:0] IN_RUN  = 6'b101011;
    localparam logic [5:0] IN_SLOW = 6'b111011;
    localparam logic [5:0] IN_WH   = 6'b100111;
    localparam logic [5:0] IN_RH   = 6'b101111;
    localparam logic [5:0] IN_RHS  = 6'b111111;
    localparam logic [5:0] IN_IRQ  = 6'b101001;
    localparam logic [5:0] IN_BOTH = 6'b101000;

    localparam logic [3:0] T0 = 4'b0100;
    localparam logic [3:0] T1 = 4'b0110;
    localparam logic [3:0] T2 = 4'b1000;
    localparam logic [3:0] T3 = 4'b1001;
    localparam logic [3:0] LI = 4'b1011;
    localparam logic [7:0] RST_V = 8'b0100_1011;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [3:0] tops [4];

    cpu6502_bus_seq_if bus();

    cpu6502_bus_seq #(
        .DIV(4),
        .SLOW_WAIT(2),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply inputs just after posedge, queue expected mid-cycle view
    task automatic step(input logic [5:0] in_v, input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        {bus.enable, bus.slow, bus.rw_n, bus.halt_req, bus.irq_n_in, bus.nmi_n_in} = in_v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One unstretched 4-clk cycle with constant inputs and status bits
    task automatic run_cycle(input logic [5:0] in_v, input logic [3:0] low, input string nm);
        for (int k = 0; k < 4; k++) step(in_v, {tops[k], low}, nm);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [7:0] got;
        logic [7:0] e;
        string      nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {bus.phi2, bus.phi0, bus.ce_rise, bus.ce_fall,
                   bus.rdy, bus.halt_ack, bus.irq_n, bus.nmi_n};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s @%0t: got %b required %b", nm, $time, got, e);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: run did not complete, got timeout required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Directed stimulus
    initial begin
        n_cmp = 0;
        n_bad = 0;
        tops[0] = T0;
        tops[1] = T1;
        tops[2] = T2;
        tops[3] = T3;
        rst = 1'b1;
        {bus.enable, bus.slow, bus.rw_n, bus.halt_req, bus.irq_n_in, bus.nmi_n_in} = IN_STOP;

        step(IN_STOP, RST_V, "reset_state");
        #6 rst = 1'b0;

        // Unstretched cycles: phi2 0,0,1,1
        run_cycle(IN_RUN, LI, "base_cycle");
        run_cycle(IN_RUN, LI, "base_cycle2");

        // slow held: phi2 high 4 clks, period 6
        step(IN_SLOW, {T0, LI}, "slow_held_c0");
        step(IN_SLOW, {T1, LI}, "slow_held_c1");
        step(IN_SLOW, {T2, LI}, "slow_held_c2");
        step(IN_SLOW, {T2, LI}, "slow_held_c3");
        step(IN_SLOW, {T2, LI}, "slow_held_c4");
        step(IN_SLOW, {T3, LI}, "slow_held_c5");

        // slow only before ce_rise: still period 6
        step(IN_SLOW, {T0, LI}, "slow_pre_c0");
        step(IN_SLOW, {T1, LI}, "slow_pre_c1");
        step(IN_RUN,  {T2, LI}, "slow_pre_c2");
        step(IN_RUN,  {T2, LI}, "slow_pre_c3");
        step(IN_RUN,  {T2, LI}, "slow_pre_c4");
        step(IN_RUN,  {T3, LI}, "slow_pre_c5");

        // slow only after ce_rise: period 4
        step(IN_RUN,  {T0, LI}, "slow_post_c0");
        step(IN_RUN,  {T1, LI}, "slow_post_c1");
        step(IN_SLOW, {T2, LI}, "slow_post_c2");
        step(IN_SLOW, {T3, LI}, "slow_post_c3");

        // Halt across write, write, read, then drop
        run_cycle(IN_WH,  LI,      "halt_write_a");
        run_cycle(IN_WH,  4'b0011, "halt_write_b");
        run_cycle(IN_RH,  4'b0011, "halt_read_c");
        run_cycle(IN_RUN, 4'b0111, "halt_drop_d");
        run_cycle(IN_RUN, LI,      "halt_done_e");

        // irq_n_in low at c1, nmi_n_in low at c2
        step(IN_RUN,  {T0, LI}, "int_f_c0");
        step(IN_IRQ,  {T1, LI}, "int_f_c1");
        step(IN_BOTH, {T2, LI}, "int_f_c2");
        step(IN_BOTH, {T3, LI}, "int_f_c3");
        run_cycle(IN_BOTH, 4'b1001, "int_g_irq_only");
        step(IN_BOTH, {T0, 4'b1000}, "int_h_c0");
        step(IN_RUN,  {T1, 4'b1000}, "int_h_c1");
        step(IN_RUN,  {T2, 4'b1000}, "int_h_c2");
        step(IN_RUN,  {T3, 4'b1000}, "int_h_c3");

        // enable freeze
        step(IN_RUN,  {T0, LI}, "en_c0");
        step(IN_STOP, {T0, LI}, "en_off_at_rise");
        step(IN_RUN,  {T1, LI}, "en_on_rise");
        for (int k = 0; k < 5; k++) step(IN_STOP, {T2, LI}, "en_off_c2");
        step(IN_RUN,  {T2, LI}, "en_resume_c2");
        step(IN_STOP, {T2, LI}, "en_off_at_fall");
        step(IN_RUN,  {T3, LI}, "en_resume_fall");

        // Reset during a stretched phi2-high phase with rdy 0 / halt_ack 1
        run_cycle(IN_RH, LI,      "prerst_j");
        run_cycle(IN_RH, 4'b0011, "prerst_k");
        step(IN_RHS, {T0, 4'b0111}, "prerst_l_c0");
        step(IN_RHS, {T1, 4'b0111}, "prerst_l_c1");
        step(IN_RH,  {T2, 4'b0111}, "prerst_l_c2");
        step(IN_RH,  {T2, 4'b0111}, "prerst_l_c3");
        step(IN_RUN, RST_V, "reset_midstretch");
        #1 rst = 1'b1;
        step(IN_RUN, RST_V, "reset_hold");
        #6 rst = 1'b0;
        step(IN_RUN, {T1, LI}, "postrst_c1");
        step(IN_RUN, {T2, LI}, "postrst_c2");
        step(IN_RUN, {T3, LI}, "postrst_c3");
        step(IN_RUN, {T0, LI}, "postrst_c0");
        step(IN_RUN, {T1, LI}, "postrst_c1b");

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
